// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory interface: default parameters, FSM state
// encoding and a small state-classification helper.
package mem_if_pkg;

    localparam int ADDR_WIDTH_DEF = 9;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } mem_state_e;

    // True while the RAM is being accessed and we may be waiting on ram_ready.
    function automatic logic is_access_state(input mem_state_e st);
        return (st == READ) || (st == WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for the memory interface timeout (used only when
// MEMIF_TIMEOUT_EN is defined). Counts enabled cycles; 'expired' is high
// during the TIMEOUT-th consecutive enabled cycle.
module mem_wait_counter
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Width only needs to hold 0..TIMEOUT-1: the count restarts on expiry.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    assign expired = enable && (count_q == LAST);

    // Next count: advance while waiting, restart when idle or on expiry.
    always_comb begin
        count_d = '0;
        if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = '0;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_interface.sv
// Memory interface between the CPU control unit (MAR/MDR) and a RAM with a
// ready handshake. FSM: IDLE -> READ -> LOAD -> DONE or IDLE -> WRITE -> DONE.
// All outputs are registered, decoded from the next state.
// Optional feature: define MEMIF_TIMEOUT_EN to abort a RAM access after
// TIMEOUT cycles without ram_ready (done with error=1).
module memory_interface
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           MARout,
    input  logic [31:0]           MDRout,
    output logic [31:0]           Mdatain,
    output logic                  Read,
    output logic                  MDRload,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    input  logic                  ram_ready
);

    mem_state_e            state_d, state_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [31:0]           wdata_d, wdata_q;
    logic [31:0]           data_d, data_q;
    logic                  read_d, read_q;
    logic                  mdrload_d, mdrload_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;
    logic                  ram_en_d, ram_en_q;
    logic                  ram_we_d, ram_we_q;
    logic                  expired_s;

    // Only the low ADDR_WIDTH address bits select a RAM word.
    logic unused_mar_s;
    assign unused_mar_s = ^MARout[31:ADDR_WIDTH];

`ifdef MEMIF_TIMEOUT_EN
    logic err_d, err_q;
    logic wait_en_s;

    assign wait_en_s = is_access_state(state_q);

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clock   (clock),
        .clear   (clear),
        .enable  (wait_en_s),
        .expired (expired_s)
    );

    // Error flag register, high only in the DONE cycle of a timed-out access.
    always_ff @(posedge clock) begin
        if (clear) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error = err_q;
`else
    // Without the timeout feature an access waits for ram_ready forever.
    localparam int unused_timeout_p = TIMEOUT;
    assign expired_s = 1'b0;
    assign error     = 1'b0;
`endif

    // Next-state logic plus address/data latches; requests outside IDLE are dropped.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
`ifdef MEMIF_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_read) begin
                    addr_d  = MARout[ADDR_WIDTH-1:0];
                    state_d = READ;
                end else if (mem_write) begin
                    addr_d  = MARout[ADDR_WIDTH-1:0];
                    wdata_d = MDRout;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (ram_ready) begin
                    data_d  = ram_rdata;
                    state_d = LOAD;
                end else if (expired_s) begin
                    state_d = DONE;
`ifdef MEMIF_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = READ;
                end
            end
            WRITE: begin
                if (ram_ready) begin
                    state_d = DONE;
                end else if (expired_s) begin
                    state_d = DONE;
`ifdef MEMIF_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = WRITE;
                end
            end
            LOAD: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        read_d    = (state_d == LOAD);
        mdrload_d = (state_d == LOAD);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        ram_en_d  = is_access_state(state_d);
        ram_we_d  = (state_d == WRITE);
    end

    // State, latches and output registers; clear abandons any access in flight.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= 32'h0000_0000;
            data_q    <= 32'h0000_0000;
            read_q    <= 1'b0;
            mdrload_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ram_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            read_q    <= read_d;
            mdrload_q <= mdrload_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ram_en_q  <= ram_en_d;
            ram_we_q  <= ram_we_d;
        end
    end

    assign Mdatain   = data_q;
    assign Read      = read_q;
    assign MDRload   = mdrload_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9: RAM word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for ram_ready (used only with MEMIF_TIMEOUT_EN).
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port mem_read, input, 1: read request from the control unit.
REQ-006 SHALL have port mem_write, input, 1: write request from the control unit.
REQ-007 SHALL have port MARout, input, 32: address from MAR; bits [ADDR_WIDTH-1:0] used, upper bits ignored.
REQ-008 SHALL have port MDRout, input, 32: write data from MDR.
REQ-009 SHALL have port Mdatain, output, 32: read data toward MDR.
REQ-010 SHALL have port Read, output, 1: MDR input-select, high selects Mdatain.
REQ-011 SHALL have port MDRload, output, 1: MDR load-enable strobe.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port error, output, 1: timeout flag, valid with done.
REQ-015 SHALL have RAM-side ports: ram_addr out ADDR_WIDTH, ram_wdata out 32, ram_rdata in 32, ram_en out 1, ram_we out 1, ram_ready in 1.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, LOAD, DONE.
REQ-017 In IDLE, mem_read SHALL latch MARout[ADDR_WIDTH-1:0] and go to READ; mem_write SHALL latch address and MDRout and go to WRITE; mem_read wins if both are high.
REQ-018 Requests arriving outside IDLE SHALL be ignored, not queued.
REQ-019 READ SHALL drive ram_en=1, ram_we=0, ram_addr=latched address; on ram_ready=1 it SHALL capture ram_rdata into an internal data register and go to LOAD.
REQ-020 WRITE SHALL drive ram_en=1, ram_we=1, ram_addr and ram_wdata from latches; on ram_ready=1 it SHALL go to DONE.
REQ-021 LOAD SHALL last exactly one cycle with Read=1, MDRload=1, Mdatain=captured data, then go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE; a new request can be accepted in the following IDLE cycle.
REQ-023 Outside LOAD, Read and MDRload SHALL be 0 and Mdatain SHALL hold the last captured data.
REQ-024 Latency with ram_ready high on the first access cycle: read request edge N -> READ N+1, LOAD N+2, done N+3; write -> done N+2.
REQ-025 ram_en and ram_we SHALL be 0 in IDLE, LOAD and DONE.

Reset
REQ-026 clear=1 at a clock edge SHALL force IDLE from any state, including mid-access, abandoning the transaction without done.
REQ-027 After reset every output SHALL be 0: Mdatain, Read, MDRload, busy, done, error, ram_addr, ram_wdata, ram_en, ram_we; internal latches and wait counter SHALL be 0.

Configuration
REQ-028 Macro MEMIF_TIMEOUT_EN defined: a wait counter SHALL count cycles in READ/WRITE; after TIMEOUT cycles without ram_ready, the FSM SHALL go to DONE with error=1 (LOAD skipped, data register unchanged); error SHALL be 0 on successful done.
REQ-029 Macro undefined: READ/WRITE SHALL wait indefinitely; error SHALL be tied 0; no counter logic.

Structure
REQ-030 State encodings and the ADDR_WIDTH/TIMEOUT defaults SHALL live in shared package mem_if_pkg.
REQ-031 The timeout counter SHALL be sub-module mem_wait_counter (clock, clear, enable, expired), instantiated only under MEMIF_TIMEOUT_EN.

Verification
REQ-032 Read, ram_ready tied 1, ram_rdata=32'hDEADBEEF, MARout=32'h0000_0042 -> ram_addr=9'h042, LOAD cycle shows Mdatain=DEADBEEF, Read=MDRload=1; done at N+3.
REQ-033 Write, MDRout=32'h12345678, ram_ready after 3 wait cycles -> ram_we=1 for 4 cycles, ram_wdata=12345678, done 1 cycle later, no MDRload.
REQ-034 mem_read and mem_write high together, then mem_write re-asserted while busy -> only the read executes, no write.
REQ-035 clear asserted in READ cycle 2 -> next cycle IDLE, all outputs 0, no done.
REQ-036 MEMIF_TIMEOUT_EN, TIMEOUT=15, ram_ready held 0 -> done=1 with error=1 after 15 wait cycles, Mdatain unchanged.
